load_store_unit: RTL

Multi-cycle load/store stage directly downstream of the ALU in the RISC-V core. It takes the ALU result as the effective address, performs one access on a simple req/ack data bus, aligns and extends load data for register writeback, and stalls the single-cycle core until the access completes. Misaligned or unsupported accesses are rejected without a bus transaction. Bus accesses that are never acknowledged are aborted by a timeout.

---
 rtl/load_store_unit_pkg.sv | 25 ++
 rtl/load_store_unit_if.sv | 45 ++++
 rtl/load_store_unit_align.sv | 67 ++++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and constants for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Core-side request/response and data-bus signals of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;

    logic        Req_Valid_i;
    logic        Mem_Read_i;
    logic        Mem_Write_i;
    logic [2:0]  Funct3_i;
    logic [31:0] Address_i;
    logic [31:0] Store_Data_i;
    logic        Stall_o;
    logic        Done_o;
    logic [31:0] Load_Data_o;
    logic        Misaligned_o;
    logic        Timeout_o;
    logic        Bus_Req_o;
    logic        Bus_We_o;
    logic [31:0] Bus_Addr_o;
    logic [31:0] Bus_Wdata_o;
    logic [3:0]  Bus_Be_o;
    logic [31:0] Bus_Rdata_i;
    logic        Bus_Ack_i;

    // The LSU itself
    modport slave (
        input  Req_Valid_i, Mem_Read_i, Mem_Write_i, Funct3_i, Address_i,
               Store_Data_i, Bus_Rdata_i, Bus_Ack_i,
        output Stall_o, Done_o, Load_Data_o, Misaligned_o, Timeout_o,
               Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_Wdata_o, Bus_Be_o
    );

    // The core pipeline and memory that surround it
    modport master (
        output Req_Valid_i, Mem_Read_i, Mem_Write_i, Funct3_i, Address_i,
               Store_Data_i, Bus_Rdata_i, Bus_Ack_i,
        input  Stall_o, Done_o, Load_Data_o, Misaligned_o, Timeout_o,
               Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_Wdata_o, Bus_Be_o
    );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational store lane encoding, fault check and load extraction.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_offset,
    input  wire logic        i_is_store,
    input  wire logic [31:0] i_store_data,
    input  wire logic [2:0]  i_ld_funct3,
    input  wire logic [1:0]  i_ld_offset,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata,
    output logic             o_fault,
    output logic      [31:0] o_load_data
);

    logic [31:0] w_lane;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'd0;
        o_fault = 1'b0;
        case (i_funct3)
            LB, LBU: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_store_data[7:0]}};
            end
            LH, LHU: begin
                o_fault = i_offset[0];
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_store_data[15:0]}};
            end
            LW: begin
                o_fault = |i_offset;
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
            default: o_fault = 1'b1;
        endcase
        // Unsigned variants have no store meaning
        if (i_is_store && (i_funct3 == LBU || i_funct3 == LHU)) begin
            o_fault = 1'b1;
        end
        if (!i_is_store) begin
            o_be = 4'b1111;
        end
    end

    always_comb begin
        w_lane = i_rdata >> {i_ld_offset, 3'b000};
        case (i_ld_funct3)
            LB:      o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            LH:      o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            LBU:     o_load_data = {24'd0, w_lane[7:0]};
            LHU:     o_load_data = {16'd0, w_lane[15:0]};
            default: o_load_data = w_lane;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Multi-cycle load/store stage on a req/ack bus with fault/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    load_store_unit_if.slave   lsu
);

    localparam int              c_cnt_w   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              c_to_en   = (TIMEOUT_CYCLES > 0);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t           r_state;
    logic [2:0]           r_funct3;
    logic [1:0]           r_offset;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;
    logic                 r_req;
    logic                 r_done;
    logic                 r_misaligned;
    logic                 r_timeout;
    logic [31:0]          r_load_data;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_accept;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic                 w_fault;
    logic [31:0]          w_load_data;

    assign w_accept = lsu.Req_Valid_i & (lsu.Mem_Read_i | lsu.Mem_Write_i);

    // Store side uses the live request; load side uses what was latched
    lsu_align u_align (
        .i_funct3     (lsu.Funct3_i),
        .i_offset     (lsu.Address_i[1:0]),
        .i_is_store   (lsu.Mem_Write_i),
        .i_store_data (lsu.Store_Data_i),
        .i_ld_funct3  (r_funct3),
        .i_ld_offset  (r_offset),
        .i_rdata      (lsu.Bus_Rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_fault      (w_fault),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_funct3     <= 3'd0;
            r_offset     <= 2'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_req        <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
            r_load_data  <= 32'd0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= lsu.Funct3_i;
                        r_offset <= lsu.Address_i[1:0];
                        r_we     <= lsu.Mem_Write_i;
                        r_addr   <= {lsu.Address_i[31:2], 2'b00};
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_count  <= '0;
                        if (w_fault) begin
                            r_state      <= S_ERR;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (lsu.Bus_Ack_i) begin
                        r_state     <= S_DONE;
                        r_req       <= 1'b0;
                        r_done      <= 1'b1;
                        r_load_data <= r_we ? 32'd0 : w_load_data;
                    end else if (c_to_en && r_count == c_to_last) begin
                        r_state     <= S_ERR;
                        r_req       <= 1'b0;
                        r_done      <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_load_data <= 32'd0;
                    end else begin
                        r_count <= r_count + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_timeout    <= 1'b0;
                    r_load_data  <= 32'd0;
                end
            endcase
        end
    end

    assign lsu.Stall_o      = (r_state == S_IDLE && w_accept) || (r_state == S_REQ);
    assign lsu.Done_o       = r_done;
    assign lsu.Load_Data_o  = r_load_data;
    assign lsu.Misaligned_o = r_misaligned;
    assign lsu.Timeout_o    = r_timeout;
    assign lsu.Bus_Req_o    = r_req;
    assign lsu.Bus_We_o     = r_we;
    assign lsu.Bus_Addr_o   = r_addr;
    assign lsu.Bus_Wdata_o  = r_wdata;
    assign lsu.Bus_Be_o     = r_be;

endmodule
`default_nettype wire
